// File: rtl/eth_pkg.sv
// Ethernet receive constants, FSM state encoding and a bit-reverse helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package eth_pkg;

   localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam int          ETH_HDR_LEN   = 14;
   localparam int          ETH_FCS_LEN   = 4;
   localparam int          ETH_MIN_FRAME = 64;
   localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   // Residue in normal (MSB-first) bit order; the reflected register is
   // bit-reversed before it is compared with this.
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAY_IP,
      ST_PAY_ARP,
      ST_DROP
   } rx_state_e;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_rx_dispatch_if.sv
// Bundle between the GMII RX byte stream, the dispatcher and the ip_rx/arp_rx consumers.
// Latency: none (wiring only).
// Backpressure: none; the RX stream cannot be stalled and consumers must take every valid byte.
//   master: the dispatcher (consumes rx_en/rx_data/local_mac_addr, produces payload + status)
//   slave : the surrounding logic (drives the byte stream, consumes payload + status)
interface mac_rx_dispatch_if;

   logic        rx_en;
   logic [7:0]  rx_data;
   logic [47:0] local_mac_addr;
   logic        ip_rx_valid;
   logic        arp_rx_valid;
   logic [7:0]  rx_dataout;
   logic        rx_sof;
   logic        rx_frame_done;
   logic        rx_frame_err;
   logic [47:0] rx_dest_mac;
   logic [47:0] rx_sour_mac;

   modport master (
      input  rx_en, rx_data, local_mac_addr,
      output ip_rx_valid, arp_rx_valid, rx_dataout, rx_sof,
             rx_frame_done, rx_frame_err, rx_dest_mac, rx_sour_mac
   );

   modport slave (
      output rx_en, rx_data, local_mac_addr,
      input  ip_rx_valid, arp_rx_valid, rx_dataout, rx_sof,
             rx_frame_done, rx_frame_err, rx_dest_mac, rx_sour_mac
   );

endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 accumulator (Ethernet FCS), no final inversion applied.
// Latency: 1 cycle; crc_o reflects every byte accepted up to the previous edge.
// Backpressure: none; en_i qualifies each byte.
// Ports: clk, rstn (sync, active-low); clr_i restarts from the init value (combines with en_i
//        so the first byte of a frame is folded in on the same edge); en_i/data_i byte input;
//        crc_o running register.
module crc32_d8
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);
   import eth_pkg::*;

   localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

   logic [31:0] crc_q, crc_d;
   logic [31:0] base;
   logic [31:0] nxt;

   always_comb begin
      base = clr_i ? CRC32_INIT : crc_q;
      nxt  = base ^ {24'h0, data_i};
      for (int i = 0; i < 8; i++) begin
         nxt = nxt[0] ? ((nxt >> 1) ^ POLY_REFL) : (nxt >> 1);
      end
      crc_d = en_i ? nxt : base;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         crc_q <= CRC32_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/mac_rx_dispatch.sv
// Parses the Ethernet header, filters on dest MAC, strips the FCS and steers payload to IP or ARP.
// Latency: a payload byte is emitted the cycle after the 4th following byte is received.
// Backpressure: none; the RX stream cannot stall and consumers must accept every valid byte.
// Ports: clk, rstn (sync, active-low); bus (mac_rx_dispatch_if.master) carries rx_en/rx_data/
//        local_mac_addr in and ip_rx_valid/arp_rx_valid/rx_dataout/rx_sof/rx_frame_done/
//        rx_frame_err/rx_dest_mac/rx_sour_mac out.
// Build option: MAC_RX_FCS_CHECK_EN adds a CRC-32 check whose failure sets rx_frame_err.
module mac_rx_dispatch #(
   parameter int          MAX_PAYLOAD  = 1500,
   parameter logic [15:0] ETH_TYPE_IP  = eth_pkg::ETH_TYPE_IP,
   parameter logic [15:0] ETH_TYPE_ARP = eth_pkg::ETH_TYPE_ARP
) (
   input  logic              clk,
   input  logic              rstn,
   mac_rx_dispatch_if.master bus
);
   import eth_pkg::*;

   // Frame byte index at which the first payload byte leaves the FCS line,
   // and the index past which payload is no longer emitted (oversize).
   localparam logic [10:0] PAY_FIRST = 11'(ETH_HDR_LEN + ETH_FCS_LEN);
   localparam logic [10:0] EMIT_END  = 11'(ETH_HDR_LEN + ETH_FCS_LEN + MAX_PAYLOAD);
   localparam logic [10:0] MIN_FRAME = 11'(ETH_MIN_FRAME);

   rx_state_e        state_q, state_d;
   logic             rx_en_q;
   logic [10:0]      cnt_q, cnt_d;
   logic [47:0]      lmac_q, lmac_d;
   logic [47:0]      dest_sh_q, dest_sh_d;
   logic [47:0]      src_sh_q, src_sh_d;
   logic [7:0]       type_hi_q, type_hi_d;
   logic [47:0]      dest_mac_q, dest_mac_d;
   logic [47:0]      sour_mac_q, sour_mac_d;
   logic [3:0][7:0]  line_q, line_d;
   logic             oversize_q, oversize_d;
   logic             ip_vld_q, ip_vld_d;
   logic             arp_vld_q, arp_vld_d;
   logic [7:0]       dout_q, dout_d;
   logic             sof_q, sof_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             start;
   logic             hdr_byte;
   logic [10:0]      hdr_idx;
   logic [10:0]      cnt_inc;
   logic             pay_st;
   logic             leave;
   logic             emit;
   logic             mac_ok;
   logic [15:0]      etype;
   logic             crc_bad;

   // A frame starts only on a rising rx_en; rx_en_q resets high so a frame
   // interrupted by reset is ignored until rx_en has been seen low.
   assign start    = bus.rx_en && !rx_en_q && (state_q == ST_IDLE);
   assign hdr_byte = start || ((state_q == ST_HDR) && bus.rx_en);
   assign hdr_idx  = start ? 11'd0 : cnt_q;
   assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign pay_st   = (state_q == ST_PAY_IP) || (state_q == ST_PAY_ARP);
   // The line holds 4 bytes; the oldest leaves only once a 5th arrives, so
   // the trailing 4 bytes (the FCS) are never emitted.
   assign leave    = pay_st && bus.rx_en && (cnt_q >= PAY_FIRST);
   assign emit     = leave && (cnt_q < EMIT_END);
   assign mac_ok   = (dest_sh_q == lmac_q) || (dest_sh_q == ETH_BCAST_MAC);
   assign etype    = {type_hi_q, bus.rx_data};

`ifdef MAC_RX_FCS_CHECK_EN
   logic [31:0] crc_w;

   crc32_d8 u_crc (
      .clk    (clk),
      .rstn   (rstn),
      .clr_i  (start),
      .en_i   (start || (bus.rx_en && (state_q != ST_IDLE))),
      .data_i (bus.rx_data),
      .crc_o  (crc_w)
   );

   assign crc_bad = (bitrev32(crc_w) != CRC32_RESIDUE);
`else
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lmac_d     = lmac_q;
      dest_sh_d  = dest_sh_q;
      src_sh_d   = src_sh_q;
      type_hi_d  = type_hi_q;
      dest_mac_d = dest_mac_q;
      sour_mac_d = sour_mac_q;
      line_d     = line_q;
      oversize_d = oversize_q;
      ip_vld_d   = 1'b0;
      arp_vld_d  = 1'b0;
      dout_d     = dout_q;
      sof_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;

      // Header bytes arrive MSB first: 0-5 dest, 6-11 source, 12-13 type.
      if (hdr_byte) begin
         if (hdr_idx < 11'd6) begin
            dest_sh_d = {dest_sh_q[39:0], bus.rx_data};
         end else if (hdr_idx < 11'd12) begin
            src_sh_d = {src_sh_q[39:0], bus.rx_data};
         end else if (hdr_idx == 11'd12) begin
            type_hi_d = bus.rx_data;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_HDR;
               cnt_d      = 11'd1;
               lmac_d     = bus.local_mac_addr;
               oversize_d = 1'b0;
            end
         end
         ST_HDR: begin
            if (!bus.rx_en) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_q == 11'd13) begin
                  dest_mac_d = dest_sh_q;
                  sour_mac_d = src_sh_q;
                  if (mac_ok && (etype == ETH_TYPE_IP)) begin
                     state_d = ST_PAY_IP;
                  end else if (mac_ok && (etype == ETH_TYPE_ARP)) begin
                     state_d = ST_PAY_ARP;
                  end else begin
                     state_d = ST_DROP;
                  end
               end
            end
         end
         ST_PAY_IP, ST_PAY_ARP: begin
            if (!bus.rx_en) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = (cnt_q < MIN_FRAME) || oversize_q || crc_bad;
            end else begin
               cnt_d  = cnt_inc;
               line_d = {line_q[2:0], bus.rx_data};
               if (emit) begin
                  dout_d    = line_q[3];
                  ip_vld_d  = (state_q == ST_PAY_IP);
                  arp_vld_d = (state_q == ST_PAY_ARP);
                  sof_d     = (cnt_q == PAY_FIRST);
               end
               if (leave && !emit) begin
                  oversize_d = 1'b1;
               end
            end
         end
         ST_DROP: begin
            if (!bus.rx_en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         rx_en_q    <= 1'b1;
         cnt_q      <= '0;
         lmac_q     <= '0;
         dest_sh_q  <= '0;
         src_sh_q   <= '0;
         type_hi_q  <= '0;
         dest_mac_q <= '0;
         sour_mac_q <= '0;
         line_q     <= '0;
         oversize_q <= 1'b0;
         ip_vld_q   <= 1'b0;
         arp_vld_q  <= 1'b0;
         dout_q     <= '0;
         sof_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_en_q    <= bus.rx_en;
         cnt_q      <= cnt_d;
         lmac_q     <= lmac_d;
         dest_sh_q  <= dest_sh_d;
         src_sh_q   <= src_sh_d;
         type_hi_q  <= type_hi_d;
         dest_mac_q <= dest_mac_d;
         sour_mac_q <= sour_mac_d;
         line_q     <= line_d;
         oversize_q <= oversize_d;
         ip_vld_q   <= ip_vld_d;
         arp_vld_q  <= arp_vld_d;
         dout_q     <= dout_d;
         sof_q      <= sof_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.ip_rx_valid   = ip_vld_q;
   assign bus.arp_rx_valid  = arp_vld_q;
   assign bus.rx_dataout    = dout_q;
   assign bus.rx_sof        = sof_q;
   assign bus.rx_frame_done = done_q;
   assign bus.rx_frame_err  = err_q;
   assign bus.rx_dest_mac   = dest_mac_q;
   assign bus.rx_sour_mac   = sour_mac_q;

endmodule

// File: tb/tb_mac_rx_dispatch.sv
// Self-checking bench for mac_rx_dispatch: table of frames plus hand-written corner sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mac_rx_dispatch;

   localparam logic [47:0] LOCAL  = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_99;
   localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRC_A  = 48'h02_11_22_33_44_50;
   localparam int          MAXP   = 1500;
`ifdef MAC_RX_FCS_CHECK_EN
   localparam bit          FCS_EN = 1'b1;
`else
   localparam bit          FCS_EN = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic       arp;
      logic       sof;
      logic [7:0] data;
   } exp_byte_t;
   typedef struct {
      string       name;
      logic [47:0] dest;
      logic [15:0] et;
      int          plen;
      int          exp_bytes;
      int          exp_done;
      logic        exp_err;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mac_rx_dispatch_if bus ();

   mac_rx_dispatch #(.MAX_PAYLOAD(MAXP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int        checks   = 0;
   int        errors   = 0;
   int        n_bytes  = 0;
   int        n_done   = 0;
   logic      last_err = 1'b0;
   exp_byte_t sb_q[$];
   logic      exp_err_q[$];
   vec_t      vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Standard Ethernet FCS: reflected CRC-32, final inversion, sent low byte first.
   function automatic logic [31:0] fcs_of(input bq_t b);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   function automatic bq_t build_frame(input logic [47:0] dest, input logic [47:0] src,
                                       input logic [15:0] et, input int plen,
                                       input int seed, input bit corrupt);
      bq_t         b;
      logic [31:0] f;
      for (int i = 0; i < 6; i++) b.push_back(dest[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
      b.push_back(et[15:8]);
      b.push_back(et[7:0]);
      for (int i = 0; i < plen; i++) b.push_back(8'(i + seed));
      f = fcs_of(b);
      if (corrupt) f[13] = ~f[13];
      for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
      return b;
   endfunction

   // Reference model: what a routed frame should produce on the outputs.
   function automatic void expect_frame(input logic [47:0] dest, input logic [15:0] et,
                                        input int plen, input int seed, input bit corrupt);
      int path;
      int n;
      path = 0;
      if (dest == LOCAL || dest == BCAST) begin
         if (et == 16'h0800) path = 1;
         else if (et == 16'h0806) path = 2;
      end
      if (path == 0) return;
      n = (plen > MAXP) ? MAXP : plen;
      for (int i = 0; i < n; i++) sb_q.push_back({1'(path == 2), 1'(i == 0), 8'(i + seed)});
      exp_err_q.push_back((plen + 18 < 64) || (plen > MAXP) || (FCS_EN && corrupt));
   endfunction

   // Drives the first n bytes of b, then one low cycle, then idle cycles.
   // rst_at >= 0 pulses rstn during that byte while the frame continues.
   task automatic drive(input bq_t b, input int n, input int rst_at, input int idle);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst_at >= 0 && i == rst_at + 1) begin
            chk("rst_mid_valid", {bus.ip_rx_valid, bus.arp_rx_valid, bus.rx_sof, bus.rx_frame_done}, 0);
            chk("rst_mid_dest", bus.rx_dest_mac, 0);
         end
         rstn       = (i != rst_at);
         bus.rx_en   = 1'b1;
         bus.rx_data = b[i];
      end
      @(negedge clk);
      rstn        = 1'b1;
      bus.rx_en   = 1'b0;
      bus.rx_data = 8'h00;
      repeat (idle) @(negedge clk);
   endtask

   task automatic monitor();
      exp_byte_t e;
      forever begin
         @(negedge clk);
         if (bus.ip_rx_valid || bus.arp_rx_valid) begin
            n_bytes++;
            chk("path_excl", bus.ip_rx_valid & bus.arp_rx_valid, 0);
            chk("sb_has_byte", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("pay_byte", {bus.arp_rx_valid, bus.rx_sof, bus.rx_dataout}, e);
            end
         end else begin
            chk("sof_alone", bus.rx_sof, 0);
         end
         if (bus.rx_frame_done) begin
            n_done++;
            last_err = bus.rx_frame_err;
            chk("sb_has_done", exp_err_q.size() > 0, 1);
            if (exp_err_q.size() > 0) chk("done_err", bus.rx_frame_err, exp_err_q.pop_front());
         end
      end
   endtask

   initial begin
      bq_t fb;
      int  b0;
      int  d0;

      vecs[0] = '{"ip_uni",   LOCAL, 16'h0800,   46,   46, 1, 1'b0};
      vecs[1] = '{"arp_bc",   BCAST, 16'h0806,   46,   46, 1, 1'b0};
      vecs[2] = '{"nonlocal", OTHER, 16'h0800,   46,    0, 0, 1'b0};
      vecs[3] = '{"ipv6",     LOCAL, 16'h86DD,   46,    0, 0, 1'b0};
      vecs[4] = '{"over1600", LOCAL, 16'h0800, 1600, 1500, 1, 1'b1};
      vecs[5] = '{"runt40",   LOCAL, 16'h0800,   22,   22, 1, 1'b1};
      vecs[6] = '{"runt63",   LOCAL, 16'h0806,   45,   45, 1, 1'b1};
      vecs[7] = '{"max1500",  LOCAL, 16'h0800, 1500, 1500, 1, 1'b0};
      vecs[8] = '{"over1501", LOCAL, 16'h0800, 1501, 1500, 1, 1'b1};
      vecs[9] = '{"arp_uni",  LOCAL, 16'h0806,   60,   60, 1, 1'b0};

      bus.rx_en          = 1'b0;
      bus.rx_data        = 8'h00;
      bus.local_mac_addr = LOCAL;
      rstn               = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ip_vld",  bus.ip_rx_valid, 0);
      chk("rst_arp_vld", bus.arp_rx_valid, 0);
      chk("rst_dout",    bus.rx_dataout, 0);
      chk("rst_sof",     bus.rx_sof, 0);
      chk("rst_done",    bus.rx_frame_done, 0);
      chk("rst_err",     bus.rx_frame_err, 0);
      chk("rst_dest",    bus.rx_dest_mac, 0);
      chk("rst_sour",    bus.rx_sour_mac, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      fork
         monitor();
      join_none

      for (int i = 0; i < 10; i++) begin
         b0 = n_bytes;
         d0 = n_done;
         fb = build_frame(vecs[i].dest, SRC_A + 48'(i), vecs[i].et, vecs[i].plen, i * 3, 1'b0);
         expect_frame(vecs[i].dest, vecs[i].et, vecs[i].plen, i * 3, 1'b0);
         drive(fb, fb.size(), -1, 4);
         chk({vecs[i].name, "_bytes"}, n_bytes - b0, vecs[i].exp_bytes);
         chk({vecs[i].name, "_done"}, n_done - d0, vecs[i].exp_done);
         if (vecs[i].exp_done != 0) chk({vecs[i].name, "_err"}, last_err, vecs[i].exp_err);
         chk({vecs[i].name, "_dest"}, bus.rx_dest_mac, vecs[i].dest);
         chk({vecs[i].name, "_sour"}, bus.rx_sour_mac, SRC_A + 48'(i));
      end

      // Header abort after 8 bytes: no done, captured MACs keep the previous frame's values.
      d0 = n_done;
      fb = build_frame(LOCAL, 48'h02_AA_AA_AA_AA_AA, 16'h0800, 46, 0, 1'b0);
      drive(fb, 8, -1, 4);
      chk("abort_done", n_done - d0, 0);
      chk("abort_dest", bus.rx_dest_mac, vecs[9].dest);
      chk("abort_sour", bus.rx_sour_mac, SRC_A + 48'd9);

      // One flipped FCS bit: flagged only when the CRC check is built in.
      fb = build_frame(LOCAL, SRC_A, 16'h0800, 46, 5, 1'b1);
      expect_frame(LOCAL, 16'h0800, 46, 5, 1'b1);
      drive(fb, fb.size(), -1, 4);
      chk("fcs_flip_err", last_err, FCS_EN);

      // Back-to-back frames with a single low cycle between them.
      b0 = n_bytes;
      d0 = n_done;
      fb = build_frame(LOCAL, 48'h02_00_00_00_0B_01, 16'h0800, 46, 7, 1'b0);
      expect_frame(LOCAL, 16'h0800, 46, 7, 1'b0);
      drive(fb, fb.size(), -1, 0);
      fb = build_frame(BCAST, 48'h02_00_00_00_0B_02, 16'h0806, 60, 9, 1'b0);
      expect_frame(BCAST, 16'h0806, 60, 9, 1'b0);
      drive(fb, fb.size(), -1, 4);
      chk("b2b_done", n_done - d0, 2);
      chk("b2b_bytes", n_bytes - b0, 106);
      chk("b2b_sour", bus.rx_sour_mac, 48'h02_00_00_00_0B_02);

      // Reset at frame byte 44 (payload byte 30): payload 0..25 already left the line.
      b0 = n_bytes;
      d0 = n_done;
      fb = build_frame(LOCAL, SRC_A, 16'h0800, 46, 11, 1'b0);
      for (int i = 0; i < 26; i++) sb_q.push_back({1'b0, 1'(i == 0), 8'(i + 11)});
      drive(fb, fb.size(), 44, 4);
      chk("rst_frame_done", n_done - d0, 0);
      chk("rst_frame_bytes", n_bytes - b0, 26);
      chk("rst_frame_sb", sb_q.size(), 0);
      chk("rst_frame_dest", bus.rx_dest_mac, 0);

      // Recovery frame after the reset.
      b0 = n_bytes;
      d0 = n_done;
      fb = build_frame(LOCAL, 48'h02_00_00_00_0C_01, 16'h0800, 46, 13, 1'b0);
      expect_frame(LOCAL, 16'h0800, 46, 13, 1'b0);
      drive(fb, fb.size(), -1, 4);
      chk("recover_done", n_done - d0, 1);
      chk("recover_bytes", n_bytes - b0, 46);
      chk("recover_err", last_err, 0);

      chk("end_sb_empty", sb_q.size(), 0);
      chk("end_done_empty", exp_err_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
